// File: rtl/frv_mem_arb_pkg.sv
// Shared definitions for the instruction/data memory arbiter: owner encoding
// and the pointer-width helper used to size the owner FIFO.
package frv_mem_arb_pkg;

    localparam logic OWNER_IMEM = 1'b0;
    localparam logic OWNER_DMEM = 1'b1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/frv_arb_owner_fifo.sv
// In-order owner FIFO: remembers which requester issued each accepted
// transaction so its response can be routed back. One bit per entry.
module frv_arb_owner_fifo
    import frv_mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic g_clk,
    input  logic g_reset,
    input  logic i_push,
    input  logic i_push_owner,
    input  logic i_pop,
    output logic o_full,
    output logic o_empty,
    output logic o_head
);

    // A depth of one still needs a one-bit pointer; it simply never leaves zero.
    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_owner;
        end
    end

endmodule

// File: rtl/frv_mem_arbiter.sv
// Shares one memory port between imem and dmem with zero added latency.
// Define FRV_MEM_ARB_RR_EN for round-robin instead of fixed dmem priority.
module frv_mem_arbiter
    import frv_mem_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int XLEN        = 32
) (
    input  logic            g_clk,
    input  logic            g_reset,

    input  logic            imem_req,
    input  logic            imem_wen,
    input  logic [3:0]      imem_strb,
    input  logic [XLEN-1:0] imem_wdata,
    input  logic [XLEN-1:0] imem_addr,
    output logic            imem_gnt,
    output logic            imem_recv,
    input  logic            imem_ack,
    output logic            imem_error,
    output logic [XLEN-1:0] imem_rdata,

    input  logic            dmem_req,
    input  logic            dmem_wen,
    input  logic [3:0]      dmem_strb,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic [XLEN-1:0] dmem_addr,
    output logic            dmem_gnt,
    output logic            dmem_recv,
    input  logic            dmem_ack,
    output logic            dmem_error,
    output logic [XLEN-1:0] dmem_rdata,

    output logic            mem_req,
    output logic            mem_wen,
    output logic [3:0]      mem_strb,
    output logic [XLEN-1:0] mem_wdata,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_recv,
    output logic            mem_ack,
    input  logic            mem_error,
    input  logic [XLEN-1:0] mem_rdata
);

    logic r_lock;
    logic r_lock_sel;
`ifdef FRV_MEM_ARB_RR_EN
    logic r_last;
`endif

    logic w_sel;
    logic w_sel_req;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_push;
    logic w_pop;

    // A stalled request keeps the port until it is granted.
    always_comb begin
        w_sel = OWNER_IMEM;
        if (r_lock) begin
            w_sel = r_lock_sel;
`ifdef FRV_MEM_ARB_RR_EN
        end else if (imem_req && dmem_req) begin
            w_sel = ~r_last;
`endif
        end else if (dmem_req) begin
            w_sel = OWNER_DMEM;
        end
    end

    assign w_sel_req = (w_sel == OWNER_DMEM) ? dmem_req : imem_req;
    assign mem_req   = w_sel_req && !w_full && !g_reset;
    assign mem_wen   = (w_sel == OWNER_DMEM) ? dmem_wen   : imem_wen;
    assign mem_strb  = (w_sel == OWNER_DMEM) ? dmem_strb  : imem_strb;
    assign mem_wdata = (w_sel == OWNER_DMEM) ? dmem_wdata : imem_wdata;
    assign mem_addr  = (w_sel == OWNER_DMEM) ? dmem_addr  : imem_addr;

    assign w_push   = mem_req && mem_gnt;
    assign imem_gnt = w_push && (w_sel == OWNER_IMEM);
    assign dmem_gnt = w_push && (w_sel == OWNER_DMEM);

    // With nothing outstanding, a response is spurious: ack it and drop it.
    always_comb begin
        imem_recv  = 1'b0;
        imem_error = 1'b0;
        imem_rdata = '0;
        dmem_recv  = 1'b0;
        dmem_error = 1'b0;
        dmem_rdata = '0;
        mem_ack    = 1'b0;
        if (!g_reset) begin
            if (w_empty) begin
                mem_ack = mem_recv;
            end else if (w_head == OWNER_DMEM) begin
                dmem_recv  = mem_recv;
                dmem_error = mem_error;
                dmem_rdata = mem_rdata;
                mem_ack    = dmem_ack;
            end else begin
                imem_recv  = mem_recv;
                imem_error = mem_error;
                imem_rdata = mem_rdata;
                mem_ack    = imem_ack;
            end
        end
    end

    assign w_pop = mem_recv && mem_ack && !w_empty;

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_lock     <= 1'b0;
            r_lock_sel <= OWNER_IMEM;
        end else if (mem_req && !mem_gnt) begin
            r_lock     <= 1'b1;
            r_lock_sel <= w_sel;
        end else if (w_push) begin
            r_lock     <= 1'b0;
        end
    end

`ifdef FRV_MEM_ARB_RR_EN
    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            r_last <= OWNER_IMEM;
        end else if (w_push) begin
            r_last <= w_sel;
        end
    end
`endif

    frv_arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .g_clk        (g_clk),
        .g_reset      (g_reset),
        .i_push       (w_push),
        .i_push_owner (w_sel),
        .i_pop        (w_pop),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_head       (w_head)
    );

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Bench for frv_mem_arbiter: directed scenarios then random traffic, all
// checked against a queue-based model of the arbitration and routing rules.
module tb_frv_mem_arbiter;

  localparam int OUTSTANDING = 2;
  localparam int XLEN        = 32;

  logic            g_clk = 1'b0;
  logic            g_reset;
  logic            imem_req, imem_wen, imem_ack;
  logic [3:0]      imem_strb;
  logic [XLEN-1:0] imem_wdata, imem_addr;
  logic            imem_gnt, imem_recv, imem_error;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req, dmem_wen, dmem_ack;
  logic [3:0]      dmem_strb;
  logic [XLEN-1:0] dmem_wdata, dmem_addr;
  logic            dmem_gnt, dmem_recv, dmem_error;
  logic [XLEN-1:0] dmem_rdata;
  logic            mem_req, mem_wen, mem_gnt, mem_recv, mem_ack, mem_error;
  logic [3:0]      mem_strb;
  logic [XLEN-1:0] mem_wdata, mem_addr, mem_rdata;

  always #5 g_clk = ~g_clk;

  frv_mem_arbiter #(.OUTSTANDING(OUTSTANDING), .XLEN(XLEN)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
    .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
    .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
    .mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: owners of outstanding transactions, in issue order.
  logic [0:0] exp_q[$];
  bit         m_locked;
  logic       m_lock_side;
  logic       m_last;

  logic            e_sel, e_mem_req, e_igs, e_dgs, e_irecv, e_drecv;
  logic            e_ierr, e_derr, e_ack;
  logic [XLEN-1:0] e_irdata, e_drdata;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_locked    = 1'b0;
    m_lock_side = 1'b0;
    m_last      = 1'b0;
  endtask

  task automatic model_eval();
    logic full;
    logic sreq;
    {e_sel, e_mem_req, e_igs, e_dgs, e_irecv, e_drecv, e_ierr, e_derr, e_ack} = '0;
    e_irdata = '0;
    e_drdata = '0;
    if (g_reset) return;
    full = (exp_q.size() >= OUTSTANDING);
    if (m_locked) e_sel = m_lock_side;
    else if (imem_req && dmem_req) begin
`ifdef FRV_MEM_ARB_RR_EN
      e_sel = ~m_last;
`else
      e_sel = 1'b1;
`endif
    end else e_sel = dmem_req;
    sreq      = e_sel ? dmem_req : imem_req;
    e_mem_req = sreq && !full;
    e_igs     = e_mem_req && mem_gnt && !e_sel;
    e_dgs     = e_mem_req && mem_gnt && e_sel;
    if (exp_q.size() == 0) begin
      e_ack = mem_recv;
    end else if (exp_q[0] == 1'b1) begin
      e_drecv = mem_recv; e_derr = mem_error; e_drdata = mem_rdata; e_ack = dmem_ack;
    end else begin
      e_irecv = mem_recv; e_ierr = mem_error; e_irdata = mem_rdata; e_ack = imem_ack;
    end
  endtask

  // Settle the combinational outputs, then compare them with the model.
  task automatic settle_check();
    #2;
    if (g_reset) model_clear();
    model_eval();
    chk("mem_req", mem_req, e_mem_req);
    chk("imem_gnt", imem_gnt, e_igs);
    chk("dmem_gnt", dmem_gnt, e_dgs);
    chk("imem_recv", imem_recv, e_irecv);
    chk("dmem_recv", dmem_recv, e_drecv);
    chk("imem_error", imem_error, e_ierr);
    chk("dmem_error", dmem_error, e_derr);
    chk("imem_rdata", imem_rdata, e_irdata);
    chk("dmem_rdata", dmem_rdata, e_drdata);
    chk("mem_ack", mem_ack, e_ack);
    if (e_mem_req) begin
      chk("mem_addr", mem_addr, e_sel ? dmem_addr : imem_addr);
      chk("mem_wdata", mem_wdata, e_sel ? dmem_wdata : imem_wdata);
      chk("mem_strb", mem_strb, e_sel ? dmem_strb : imem_strb);
      chk("mem_wen", mem_wen, e_sel ? dmem_wen : imem_wen);
    end
  endtask

  // Advance one clock and apply the transfers the model predicted.
  task automatic clock_edge();
    logic push, pop;
    push = e_mem_req && mem_gnt;
    pop  = mem_recv && e_ack && (exp_q.size() > 0);
    @(posedge g_clk);
    if (!g_reset) begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        exp_q.push_back(e_sel);
        m_last   = e_sel;
        m_locked = 1'b0;
      end else if (e_mem_req) begin
        m_locked    = 1'b1;
        m_lock_side = e_sel;
      end
    end
    #1;
  endtask

  task automatic step();
    settle_check();
    clock_edge();
  endtask

  task automatic drive_idle();
    imem_req = 0; imem_wen = 0; imem_strb = 4'h0; imem_wdata = '0; imem_addr = '0; imem_ack = 0;
    dmem_req = 0; dmem_wen = 0; dmem_strb = 4'h0; dmem_wdata = '0; dmem_addr = '0; dmem_ack = 0;
    mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = '0;
  endtask

  initial begin
    int grants;
    logic [0:0] order_q[$];
    logic [0:0] want;
    drive_idle();
    g_reset = 1'b1;
    model_clear();
    step();
    step();
    g_reset = 1'b0;
    step();

    // Contention under fixed priority: dmem first, imem next cycle.
    imem_req = 1; imem_addr = 32'h8000_0000;
    dmem_req = 1; dmem_addr = 32'h0000_1000; dmem_wen = 1; dmem_strb = 4'hF; dmem_wdata = 32'h1234_5678;
    mem_gnt = 1;
`ifndef FRV_MEM_ARB_RR_EN
    settle_check();
    chk("cont_dmem_gnt", dmem_gnt, 1'b1);
    chk("cont_imem_gnt", imem_gnt, 1'b0);
    chk("cont_addr", mem_addr, 32'h0000_1000);
    clock_edge();
    dmem_req = 0;
    settle_check();
    chk("cont_imem_next", imem_gnt, 1'b1);
    clock_edge();
    imem_req = 0; mem_gnt = 0;
    mem_recv = 1; imem_ack = 1; dmem_ack = 1;
    step();
    step();
    mem_recv = 0; imem_ack = 0; dmem_ack = 0;
`else
    imem_req = 0; dmem_req = 0; mem_gnt = 0;
`endif

    // Lock: imem stalls three cycles, dmem arrives meanwhile.
    imem_req = 1; imem_addr = 32'h8000_0000; mem_gnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin dmem_req = 1; dmem_addr = 32'h0000_1000; end
      settle_check();
      chk("lock_addr", mem_addr, 32'h8000_0000);
      clock_edge();
    end
    mem_gnt = 1;
    settle_check();
    chk("lock_imem_gnt", imem_gnt, 1'b1);
    chk("lock_dmem_gnt", dmem_gnt, 1'b0);
    clock_edge();
    imem_req = 0;
    step();
    dmem_req = 0; mem_gnt = 0;

    // Responses return imem first, then dmem; imem stalls one cycle.
    mem_recv = 1; mem_rdata = 32'hAAAA_0000; imem_ack = 0; dmem_ack = 1;
    settle_check();
    chk("resp_stall_recv", imem_recv, 1'b1);
    chk("resp_stall_ack", mem_ack, 1'b0);
    clock_edge();
    imem_ack = 1;
    settle_check();
    chk("resp1_rdata", imem_rdata, 32'hAAAA_0000);
    chk("resp1_dmem_recv", dmem_recv, 1'b0);
    clock_edge();
    mem_rdata = 32'h5555_0000;
    settle_check();
    chk("resp2_rdata", dmem_rdata, 32'h5555_0000);
    chk("resp2_dmem_recv", dmem_recv, 1'b1);
    clock_edge();
    mem_recv = 0; imem_ack = 0; dmem_ack = 0; mem_rdata = '0;

    // Full: two grants, then a pop in the same cycle must not admit a third.
    imem_req = 1; imem_addr = 32'h0000_0100; mem_gnt = 1;
    step();
    imem_req = 0; dmem_req = 1; dmem_addr = 32'h0000_0200;
    step();
    dmem_req = 0; imem_req = 1; imem_addr = 32'h0000_0300;
    mem_recv = 1; imem_ack = 1;
    settle_check();
    chk("full_mem_req", mem_req, 1'b0);
    chk("full_imem_gnt", imem_gnt, 1'b0);
    chk("full_pop_ack", mem_ack, 1'b1);
    clock_edge();
    mem_recv = 0; imem_ack = 0;
    settle_check();
    chk("resume_mem_req", mem_req, 1'b1);
    chk("resume_imem_gnt", imem_gnt, 1'b1);
    clock_edge();
    imem_req = 0; mem_gnt = 0;

    // Reset with transactions outstanding, then a spurious response.
    g_reset = 1; imem_req = 1; mem_gnt = 1; mem_recv = 1; dmem_ack = 1;
    settle_check();
    chk("rst_imem_gnt", imem_gnt, 1'b0);
    chk("rst_dmem_recv", dmem_recv, 1'b0);
    chk("rst_mem_ack", mem_ack, 1'b0);
    clock_edge();
    g_reset = 0; imem_req = 0; mem_gnt = 0; dmem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
    settle_check();
    chk("spurious_ack", mem_ack, 1'b1);
    chk("spurious_irecv", imem_recv, 1'b0);
    chk("spurious_drecv", dmem_recv, 1'b0);
    clock_edge();
    mem_recv = 0; mem_rdata = '0;

`ifdef FRV_MEM_ARB_RR_EN
    // One dmem-only grant, then continuous contention alternates sides.
    dmem_req = 1; mem_gnt = 1; mem_recv = 1; imem_ack = 1; dmem_ack = 1;
    step();
    imem_req = 1;
    grants = 0;
    for (int c = 0; c < 20 && grants < 4; c++) begin
      settle_check();
      if (imem_gnt) begin order_q.push_back(1'b0); grants++; end
      if (dmem_gnt) begin order_q.push_back(1'b1); grants++; end
      clock_edge();
    end
    chk("rr_grant_count", grants, 4);
    for (int k = 0; k < 4; k++) begin
      want = k[0];
      chk("rr_order", (k < order_q.size()) ? order_q[k] : 1'bx, want);
    end
    drive_idle();
    step();
    mem_recv = 1; imem_ack = 1; dmem_ack = 1;
    step();
    step();
    mem_recv = 0; imem_ack = 0; dmem_ack = 0;
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      if (!imem_req && $urandom_range(0, 2) == 0) begin
        imem_req = 1; imem_addr = $urandom; imem_wdata = $urandom;
        imem_wen = 1'($urandom_range(0, 1)); imem_strb = 4'($urandom_range(0, 15));
      end
      if (!dmem_req && $urandom_range(0, 2) == 0) begin
        dmem_req = 1; dmem_addr = $urandom; dmem_wdata = $urandom;
        dmem_wen = 1'($urandom_range(0, 1)); dmem_strb = 4'($urandom_range(0, 15));
      end
      mem_gnt   = 1'($urandom_range(0, 1));
      mem_recv  = 1'($urandom_range(0, 1));
      mem_error = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      imem_ack  = 1'($urandom_range(0, 3) != 0);
      dmem_ack  = 1'($urandom_range(0, 3) != 0);
      step();
      if (e_igs) imem_req = 0;
      if (e_dgs) dmem_req = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
